muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit with HI/LO registers for the MIPS datapath. It takes the same rs/rt operands that feed the ALU and executes MULT, MULTU, DIV and DIVU over 32 cycles. It holds the 64-bit result in HI/LO, where the writeback mux reads it for MFHI/MFLO alongside the ALU result. MTHI/MTLO write HI/LO directly.

Parameters:
WIDTH, 32, operand and HI/LO register width; iteration count equals WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled only when busy=0
op  input  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO write data
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when HI/LO take a new mult/div result
div_by_zero  output  1  valid with done; set if a DIV/DIVU had b=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high) sets hi=0, lo=0, busy=0, done=0, div_by_zero=0, and the FSM to IDLE. Reset during RUN aborts the operation with no partial result.
- FSM states are IDLE, RUN and FINISH. An internal 5-bit (log2 WIDTH) iteration counter runs in RUN.
- IDLE with start=1 at edge E0:
  - a, b and op are latched.
  - Signed ops convert operands to magnitudes and record the result signs.
  - busy=1 and the counter is cleared.
  - Go to RUN.
- RUN performs one radix-2 step per edge:
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - After 32 steps (edges E1..E32), go to FINISH.
- FINISH at edge E33:
  - Apply sign correction.
  - Write hi/lo, set done=1 and busy=0, return to IDLE.
  - done is high for exactly the cycle after E33, then deasserts.
- Latency: busy is high for 33 cycles. The result is visible on hi/lo in the first cycle after E33. A new start is accepted in that same cycle.
- Operands a/b may change after E0 without affecting the result.
- start while busy=1 is ignored; no queueing.
- Result rules:
  - MULT: {hi,lo} = 64-bit two's-complement product.
  - MULTU: {hi,lo} = unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient to lo, remainder to hi.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- Divide by zero (DIV or DIVU with b=0):
  - Still takes the full 33 cycles.
  - Result is lo=0xFFFFFFFF, hi=a.
  - div_by_zero=1 while done=1, otherwise 0.
- MTHI/MTLO:
  - When busy=0, hi_we/lo_we write wdata into hi/lo at the edge. Visible next cycle.
  - Ignored while busy=1.
  - If start=1 and hi_we or lo_we are asserted in the same IDLE cycle, start wins and the write is dropped.
  - hi_we and lo_we together write the same wdata to both.
- hi/lo hold their value except on FINISH, an accepted MTHI/MTLO write, or reset.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002, then MULTU with the same operands -> MULT gives hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU gives hi=0x00000001, lo=0xFFFFFFFE. Check busy high exactly 33 cycles and done exactly 1 cycle.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1 only during the done cycle.
- Start MULTU 3*5 -> at cycle 10 assert start with op=DIV and change a/b -> second start ignored; result hi=0, lo=15 after 33 cycles. A start in the done cycle is accepted.
- hi_we=1, wdata=0xCAFEF00D while idle -> hi=0xCAFEF00D next cycle, lo unchanged. The same write while busy is ignored. start+lo_we in the same idle cycle -> lo_we dropped.
- reset asserted at cycle 20 of a MULT -> next cycle busy=0, done=0, hi=lo=0. A following MULTU 7*6 completes normally with lo=42.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
// It executes MULT, MULTU, DIV and DIVU with one radix-2 step per clock:
// shift-add for multiply and restoring shift-subtract for divide. The
// operands are latched when the operation starts, and the 64-bit result is
// written to HI/LO at the end. MTHI/MTLO write HI/LO directly while the
// unit is idle.
//
// Ports:
//   clk          system clock, all state updates on rising edge
//   reset        synchronous, active-high reset
//   start        begin an operation (sampled only when busy=0)
//   op           00=MULT, 01=MULTU, 10=DIV, 11=DIVU
//   a, b         rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   hi_we/lo_we  MTHI / MTLO write enables (honoured only when idle)
//   wdata        MTHI / MTLO write data
//   busy         operation in progress
//   done         one-cycle pulse when HI/LO take a new mult/div result
//   div_by_zero  valid with done; DIV/DIVU had b=0
//   hi, lo       HI / LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;

  // Working registers. For multiply acc_lo holds the multiplier, which is
  // shifted out as the product is shifted in. For divide acc_hi is the
  // partial remainder and acc_lo holds the dividend, which is shifted out
  // as the quotient bits are shifted in. opnd is |multiplicand| or |divisor|.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_lat;     // raw dividend, returned in HI on divide by zero
  logic             is_div;
  logic             neg_q;     // negate product / quotient at the end
  logic             neg_r;     // negate remainder at the end
  logic             dbz;

  // Operand conditioning at start time.
  logic             is_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // One iteration step and the final sign-corrected result.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign busy = (state != S_IDLE);

  // NOTE: every signal written in always_comb gets a default first, so no
  //       path through the block can leave it unassigned and infer a latch.
  always_comb begin
    is_signed = ~op[0];
    abs_a     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Multiply: add multiplicand if the low multiplier bit is set, then
    // shift the {carry, acc_hi, acc_lo} chain right by one.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the difference only if it did not go negative.
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = (div_shift >= {1'b0, opnd});

    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end

    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      res_lo = neg_q ? (~acc_lo + 1'b1) : acc_lo;
      res_hi = neg_r ? (~acc_hi + 1'b1) : acc_hi;
      if (dbz) begin
        res_lo = '1;
        res_hi = a_lat;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  //       samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      a_lat       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // start wins over a same-cycle MTHI/MTLO write
            is_div <= op[1];
            neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= is_signed && a[WIDTH-1];
            dbz    <= op[1] && (b == '0);
            a_lat  <= a;
            acc_hi <= '0;
            acc_lo <= op[1] ? abs_a : abs_b;
            opnd   <= op[1] ? abs_b : abs_a;
            cnt    <= '0;
            state  <= S_RUN;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= S_FINISH;
        end
        S_FINISH: begin
          hi          <= res_hi;
          lo          <= res_lo;
          done        <= 1'b1;
          div_by_zero <= dbz;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
